// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg
//   Shared definitions for the multi-cycle multiply/divide sequencer:
//   the ALU opcodes it recognises, the sequencer state encoding, the
//   divider iteration count and small opcode/arithmetic helpers.
package muldiv_ctrl_pkg;

  // Opcode values matching EXE_*_OP in defines.vh
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  // One restoring iteration per quotient bit; tied to the 32-bit operands.
  localparam int DIV_ITER = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } md_state_e;

  function automatic logic is_md(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
           (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
  endfunction

  function automatic logic is_div(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

  function automatic logic is_signed_op(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_DIV_OP);
  endfunction

  // Low 64 bits of the product of two operands sign- or zero-extended to
  // 64 bits equals the full signed/unsigned 32x32 product.
  function automatic logic [63:0] mul64(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic        sgn);
    logic [63:0] xe;
    logic [63:0] ye;
    xe = {{32{sgn & x[31]}}, x};
    ye = {{32{sgn & y[31]}}, y};
    return xe * ye;
  endfunction

  // Magnitude of a signed operand; 0x80000000 maps to 2^31 as unsigned.
  function automatic logic [31:0] magnitude(input logic [31:0] x,
                                            input logic        sgn);
    return (sgn & x[31]) ? (32'd0 - x) : x;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_core.sv
// muldiv_ctrl_div_core
//   Iterative unsigned restoring divider, one quotient bit per cycle.
//   Ports:
//     clk, resetn        clock / asynchronous active-low reset
//     start              load dividend/divisor and begin (one-cycle pulse)
//     abort              drop the operation in progress
//     dividend, divisor  32-bit unsigned magnitudes
//     done               one-cycle pulse the cycle after the last iteration
//     rem, quot          remainder / quotient, valid while done is high
module muldiv_ctrl_div_core
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] rem,
  output logic [31:0] quot
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] divisor_q, divisor_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] rem_sh;
  logic        no_borrow;

  // The quotient register doubles as the dividend shift register: each
  // step shifts its top bit into the partial remainder. When the old
  // remainder's bit 31 is set the shifted value is >= 2^32, which always
  // exceeds the divisor, so that bit alone guarantees no borrow.
  always_comb begin
    rem_sh    = {rem_q[30:0], quot_q[31]};
    no_borrow = rem_q[31] | (rem_sh >= divisor_q);

    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      rem_d     = '0;
      quot_d    = dividend;
      divisor_d = divisor;
      cnt_d     = '0;
      busy_d    = 1'b1;
    end else if (busy_q) begin
      rem_d  = no_borrow ? (rem_sh - divisor_q) : rem_sh;
      quot_d = {quot_q[30:0], no_borrow};
      cnt_d  = cnt_q + 5'd1;
      if (cnt_q == 5'(DIV_ITER - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign done = done_q;
  assign rem  = rem_q;
  assign quot = quot_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
//   Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage. Stalls the
//   pipeline while busy and presents {HI,LO} with a one-cycle done pulse.
//   Ports:
//     clk, resetn   clock / asynchronous active-low reset
//     start         EX holds a mult/div instruction and is not flushed
//     op            ALU opcode; non mult/div values are ignored
//     a, b          rs / rt operands
//     flush         abort any operation in progress
//     stall         start & is_md(op) & ~done (combinational)
//     done          registered, high for exactly one cycle per result
//     result        {hi,lo}; meaningful only while done is high
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 1
)
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [7:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [63:0] result
);

  localparam int CNT_W = (MUL_LAT > DIV_ITER) ? $clog2(MUL_LAT) : $clog2(DIV_ITER);

  md_state_e   state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sgn_q, sgn_d;
  logic [63:0] result_q, result_d;
  logic        done_q, done_d;

  logic        accept;
  logic        abort;
  logic        div_start;
  logic        div_abort;
  logic        div_done;
  logic [31:0] div_rem;
  logic [31:0] div_quot;
  logic [31:0] fix_rem;
  logic [31:0] fix_quot;

  assign accept = start & is_md(op) & ~flush;
  // Losing start mid-operation means EX no longer holds the instruction.
  assign abort  = flush | ~start;

  muldiv_ctrl_div_core u_div_core (
    .clk      (clk),
    .resetn   (resetn),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (magnitude(a, is_signed_op(op))),
    .divisor  (magnitude(b, is_signed_op(op))),
    .done     (div_done),
    .rem      (div_rem),
    .quot     (div_quot)
  );

  // Sign fix-up uses the original operand signs: the quotient is negative
  // when the signs differ, the remainder takes the dividend's sign.
  always_comb begin
    fix_quot = (sgn_q & (a_q[31] ^ b_q[31])) ? (32'd0 - div_quot) : div_quot;
    fix_rem  = (sgn_q & a_q[31]) ? (32'd0 - div_rem) : div_rem;
  end

  // Sequencer next-state. With MUL_LAT=1 the product goes straight from
  // the accept cycle into the result so the multiply stalls exactly one
  // cycle; longer latencies spend MUL_LAT-1 extra cycles in MUL.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    result_d  = result_q;
    div_start = 1'b0;
    div_abort = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d   = a;
          b_d   = b;
          sgn_d = is_signed_op(op);
          if (is_div(op)) begin
            state_d   = ST_DIV;
            counter_d = '0;
            div_start = 1'b1;
          end else if (MUL_LAT == 1) begin
            result_d = mul64(a, b, is_signed_op(op));
            state_d  = ST_DONE;
          end else begin
            state_d   = ST_MUL;
            counter_d = CNT_W'(MUL_LAT - 2);
          end
        end
      end

      ST_MUL: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (counter_q == '0) begin
          result_d = mul64(a_q, b_q, sgn_q);
          state_d  = ST_DONE;
        end else begin
          counter_d = counter_q - CNT_W'(1);
        end
      end

      ST_DIV: begin
        if (abort) begin
          state_d   = ST_IDLE;
          div_abort = 1'b1;
        end else if (counter_q == CNT_W'(DIV_ITER - 1)) begin
          state_d = ST_FIX;
        end else begin
          counter_d = counter_q + CNT_W'(1);
        end
      end

      ST_FIX: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (div_done) begin
          // Divide by zero reports the untouched dividend and all-ones.
          result_d = (b_q == '0) ? {a_q, 32'hFFFF_FFFF} : {fix_rem, fix_quot};
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign stall  = start & is_md(op) & ~done_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl
//   Scoreboard bench: the driver pushes the arithmetic expectation of each
//   issued mult/div into a queue, a negedge monitor pops and compares it
//   whenever done is seen.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int MUL_LAT = 1;
  localparam int DIV_STALL = 34;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  op = 8'h00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        done;
  logic [63:0] result;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_result = '0;
  logic [63:0] mon_exp;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  // Plain arithmetic expectation of {hi,lo}.
  function automatic logic [63:0] ref_model(input logic [7:0] o,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
    longint      sx;
    longint      sy;
    logic [63:0] ux;
    logic [63:0] uy;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      EXE_MULT_OP:  return 64'(sx * sy);
      EXE_MULTU_OP: return ux * uy;
      EXE_DIV_OP: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      EXE_DIVU_OP: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {32'(ux % uy), 32'(ux / uy)};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got result %h expected no done", result);
      end else begin
        mon_exp = exp_q.pop_front();
        check_output("result", result, mon_exp);
        last_result = mon_exp;
      end
    end
  end

  // Issue one mult/div and hold it in EX until done; called at posedge+1.
  task automatic apply_stimulus(input logic [7:0] o, input logic [31:0] x,
                                input logic [31:0] y, input bit scramble);
    int cycles;
    bit seen;
    int exp_lat;
    exp_lat = is_div(o) ? DIV_STALL : MUL_LAT;
    exp_q.push_back(ref_model(o, x, y));
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      check_output("stall_busy", {63'd0, stall}, 64'd1);
      cycles++;
      if (scramble && i > 0) begin
        a = $urandom;
        b = $urandom;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: got no done after %0d cycles expected done after %0d", cycles, exp_lat);
    end else begin
      check_output("stall_at_done", {63'd0, stall}, 64'd0);
      check_output("latency", 64'(cycles), 64'(exp_lat));
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Start an op, then abort it at cycle 'at' by flush or by dropping start.
  task automatic abort_stimulus(input logic [7:0] o, input logic [31:0] x,
                                input logic [31:0] y, input int at,
                                input bit use_flush);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    repeat (at) @(posedge clk);
    #1;
    if (use_flush) flush = 1'b1;
    else start = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_output("abort_done", {63'd0, done}, 64'd0);
      check_output("abort_result_held", result, last_result);
    end
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rop;
  logic [31:0] ra;
  logic [31:0] rb;

  initial begin
    #2;
    check_output("reset_done", {63'd0, done}, 64'd0);
    check_output("reset_result", result, 64'd0);
    check_output("reset_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    apply_stimulus(EXE_MULT_OP,  32'hFFFF_FFFE, 32'd3, 1'b0);
    apply_stimulus(EXE_MULTU_OP, 32'hFFFF_FFFE, 32'd3, 1'b0);
    apply_stimulus(EXE_DIVU_OP,  32'd100, 32'd7, 1'b1);
    apply_stimulus(EXE_DIV_OP,   32'hFFFF_FFF9, 32'd2, 1'b1);
    apply_stimulus(EXE_DIV_OP,   32'd7, 32'hFFFF_FFFE, 1'b1);
    apply_stimulus(EXE_DIV_OP,   32'h1234_5678, 32'd0, 1'b1);
    apply_stimulus(EXE_DIVU_OP,  32'h1234_5678, 32'd0, 1'b1);
    apply_stimulus(EXE_DIV_OP,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

    abort_stimulus(EXE_DIVU_OP, 32'd1000, 32'd3, 10, 1'b1);
    apply_stimulus(EXE_MULTU_OP, 32'd5, 32'd6, 1'b0);
    abort_stimulus(EXE_DIV_OP, 32'hFFFF_0000, 32'd9, 5, 1'b0);

    // Non mult/div opcode: never stalls, never completes.
    start = 1'b1;
    op = 8'h20;
    a = 32'd9;
    b = 32'd9;
    repeat (3) begin
      @(negedge clk);
      check_output("nonmd_stall", {63'd0, stall}, 64'd0);
    end
    @(posedge clk);
    #1;
    start = 1'b0;

    // Reset mid-divide clears outputs without waiting for a clock edge.
    start = 1'b1;
    op = EXE_DIVU_OP;
    a = 32'd77;
    b = 32'd5;
    repeat (15) @(posedge clk);
    #3;
    resetn = 1'b0;
    start = 1'b0;
    #1;
    check_output("async_reset_done", {63'd0, done}, 64'd0);
    check_output("async_reset_result", result, 64'd0);
    last_result = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back: the second start is the single IDLE cycle.
    apply_stimulus(EXE_MULT_OP, 32'h0001_2345, 32'hFFFF_FF00, 1'b0);
    apply_stimulus(EXE_DIV_OP,  32'h8765_4321, 32'h0000_1234, 1'b1);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: rop = EXE_MULT_OP;
        1: rop = EXE_MULTU_OP;
        2: rop = EXE_DIV_OP;
        default: rop = EXE_DIVU_OP;
      endcase
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 30);
      apply_stimulus(rop, ra, rb, 1'b1);
    end

    repeat (5) @(negedge clk);
    check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
